// File: rtl/udc_bus_loader.sv
// Configuration sequencer for the up/down counter: validates a config, writes it over the
// counter's 8-bit register bus, verifies it by readback, starts the counter and waits for ec.
module udc_bus_loader #(
    parameter int TIMEOUT = 4000,
    parameter int TO_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_start,
    input  logic [7:0] cfg_upper,
    input  logic [7:0] cfg_lower,
    input  logic [7:0] cfg_cycles,
    output logic       A0,
    output logic       A1,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    inout  wire  [7:0] din,
    output logic       start,
    input  logic       ec,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_TA    = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_START = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    logic [2:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] cfg_q, cfg_d;
    logic            mm_q, mm_d, mm_n;
    logic [TO_W-1:0] to_q, to_d, to_inc;
    logic [1:0]      err_q, err_d;
    logic            ready_q, busy_q, done_q, start_q;
    logic            ncs_q, nwr_q, nrd_q, oe_q;
    logic [1:0]      addr_q;
    logic [7:0]      dout_q;
    logic            wr_nx, rd_nx;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        mm_d    = mm_q;
        to_d    = to_q;
        err_d   = err_q;
        to_inc  = to_q + TO_ONE;
        mm_n    = mm_q | (din != cfg_q[idx_q]);
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    // byte index equals the counter register address
                    cfg_d   = {cfg_cycles, cfg_lower, cfg_upper, cfg_start};
                    err_d   = 2'b00;
                    mm_d    = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((cfg_q[2] < cfg_q[0]) && (cfg_q[0] < cfg_q[1]) && (cfg_q[3] != 8'd0)) begin
                    idx_d   = 2'd0;
                    state_d = S_WR;
                end else begin
                    err_d   = 2'b01;
                    state_d = S_FIN;
                end
            end
            S_WR: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_TA;
            end
            S_TA: begin
                idx_d   = 2'd0;
                mm_d    = 1'b0;
                state_d = S_RD;
            end
            S_RD: begin
                mm_d  = mm_n;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (mm_n) begin
                        err_d   = 2'b10;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                to_d = to_inc;
                // ec is checked first so a late ec on the timeout cycle still succeeds
                if (ec) begin
                    err_d   = 2'b00;
                    state_d = S_FIN;
                end else if (to_inc == TO_MAX) begin
                    err_d   = 2'b11;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_nx = (state_d == S_WR);
    assign rd_nx = (state_d == S_RD);

    // bus strobes and status are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cfg_q   <= '0;
            mm_q    <= 1'b0;
            to_q    <= '0;
            err_q   <= 2'b00;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            ncs_q   <= 1'b1;
            nwr_q   <= 1'b1;
            nrd_q   <= 1'b1;
            oe_q    <= 1'b0;
            addr_q  <= 2'b00;
            dout_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
            mm_q    <= mm_d;
            to_q    <= to_d;
            err_q   <= err_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FIN);
            start_q <= (state_d == S_START);
            ncs_q   <= !(wr_nx || rd_nx);
            nwr_q   <= !wr_nx;
            nrd_q   <= !rd_nx;
            oe_q    <= wr_nx;
            addr_q  <= (wr_nx || rd_nx) ? idx_d : 2'b00;
            dout_q  <= cfg_d[idx_d];
        end
    end

    assign din       = oe_q ? dout_q : 8'hzz;
    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start     = start_q;
    assign err_code  = err_q;
    assign ncs       = ncs_q;
    assign nwr       = nwr_q;
    assign nrd       = nrd_q;
    assign A1        = addr_q[1];
    assign A0        = addr_q[0];

endmodule

// File: tb/tb_udc_bus_loader.sv
// Bench for udc_bus_loader: a register-file model of the counter answers the bus, and each
// request is checked against expectations derived from the config rules and cycle timeline.
module tb_udc_bus_loader;
    localparam int TIMEOUT = 50;
    localparam int MAXC    = 120;

    typedef logic [23:0] ev_t;
    typedef ev_t evq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_start = 8'd0, cfg_upper = 8'd0, cfg_lower = 8'd0, cfg_cycles = 8'd0;
    logic       ec = 1'b0;
    wire        cfg_ready, A0, A1, ncs, nwr, nrd, start, busy, done;
    wire  [1:0] err_code;
    wire  [7:0] din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udc_bus_loader #(.TIMEOUT(TIMEOUT), .TO_W(12)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_upper(cfg_upper), .cfg_lower(cfg_lower),
        .cfg_cycles(cfg_cycles), .A0(A0), .A1(A1), .ncs(ncs), .nwr(nwr), .nrd(nrd),
        .din(din), .start(start), .ec(ec), .busy(busy), .done(done), .err_code(err_code)
    );

    // counter register file: stores written bytes, returns them on reads (optionally corrupt)
    logic [7:0] mem [4];
    logic       corrupt = 1'b0;
    logic [7:0] rd_val;
    always @(posedge clk) if (!ncs && !nwr) mem[{A1, A0}] <= din;
    always_comb rd_val = (corrupt && {A1, A0} == 2'd1) ? 8'h07 : mem[{A1, A0}];
    assign din = (!ncs && !nrd) ? rd_val : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (din[g]);
    end

    // per-request observations
    evq_t       bus_q;
    int         done_cyc, start_cnt, start_cyc, acc_wait;
    logic [1:0] done_err;
    logic [7:0] din6;
    bit         busy_all, ready_any;

    function automatic bit is_legal(input logic [7:0] s, u, l, n);
        return (l < s) && (s < u) && (n != 8'd0);
    endfunction

    function automatic evq_t exp_bus(input logic [7:0] s, u, l, n, input bit corr);
        evq_t q;
        logic [7:0] b [4];
        b = '{s, u, l, n};
        if (!is_legal(s, u, l, n)) return q;
        for (int i = 0; i < 4; i++) q.push_back({8'(2 + i), 4'h0, 1'b0, 1'b1, 2'(i), b[i]});
        for (int i = 0; i < 4; i++)
            q.push_back({8'(7 + i), 4'h0, 1'b1, 1'b0, 2'(i), (corr && i == 1) ? 8'h07 : b[i]});
        return q;
    endfunction

    function automatic void exp_result(input logic [7:0] s, u, l, n, input bit corr,
                                       input int ec_cyc, output int dc, output logic [1:0] er);
        if (!is_legal(s, u, l, n)) begin
            dc = 2; er = 2'b01;
        end else if (corr && u != 8'h07) begin
            dc = 11; er = 2'b10;
        end else if (ec_cyc >= 12 && ec_cyc < 12 + TIMEOUT) begin
            dc = ec_cyc + 1; er = 2'b00;
        end else begin
            dc = 12 + TIMEOUT; er = 2'b11;
        end
    endfunction

    // Issues one request and records what the DUT does until done (cycle 1 = after accept).
    task automatic do_req(input logic [7:0] s, u, l, n, input bit corr, input int ec_cyc,
                          input bit pend, input logic [31:0] pcfg);
        bus_q.delete();
        done_cyc = -1; start_cnt = 0; start_cyc = -1; busy_all = 1'b1; ready_any = 1'b0;
        din6 = 8'h00; acc_wait = 0; corrupt = corr; done_err = 2'b00;
        while (cfg_ready !== 1'b1 && acc_wait < MAXC) begin
            @(negedge clk);
            acc_wait++;
        end
        if (cfg_ready !== 1'b1) return;
        cfg_valid = 1'b1;
        cfg_start = s; cfg_upper = u; cfg_lower = l; cfg_cycles = n;
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk);
            if (!ncs) bus_q.push_back({8'(c), 4'h0, nwr, nrd, A1, A0, din});
            if (c == 6) din6 = din;
            if (start) begin start_cnt++; start_cyc = c; end
            if (busy !== 1'b1) busy_all = 1'b0;
            if (cfg_ready !== 1'b0) ready_any = 1'b1;
            if (done) begin
                done_cyc = c; done_err = err_code;
                break;
            end
            ec = (c == 5) || (c == ec_cyc);
            if (pend && c >= 15) begin
                cfg_valid = 1'b1;
                {cfg_start, cfg_upper, cfg_lower, cfg_cycles} = pcfg;
            end else begin
                cfg_valid = 1'b0;
                {cfg_start, cfg_upper, cfg_lower, cfg_cycles} = $urandom;
            end
        end
        ec = 1'b0;
    endtask

    function automatic logic [31:0] rand_cfg(input int mode);
        logic [7:0] s, u, l, n;
        s = 8'($urandom_range(1, 254));
        l = 8'($urandom_range(0, 32'(s) - 1));
        u = 8'($urandom_range(32'(s) + 1, 255));
        n = 8'($urandom_range(1, 255));
        case (mode)
            0: l = s;
            1: n = 8'd0;
            2: u = s;
            default: ;
        endcase
        return {s, u, l, n};
    endfunction

    task automatic test_reset();
        #2 rst = 1'b0;
        #6;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err_code); end
        checks++; if ({ncs, nwr, nrd} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b want 111", {ncs, nwr, nrd}); end
        checks++; if ({A1, A0} !== 2'b00) begin errors++; $display("FAIL reset_addr: got %b want 00", {A1, A0}); end
        checks++; if (din !== 8'hFF) begin errors++; $display("FAIL reset_din_released: got %h want ff (pulled)", din); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        evq_t exq;
        do_req(8'd4, 8'd6, 8'd3, 8'd2, 1'b0, 31, 1'b0, 32'd0);
        exq = exp_bus(8'd4, 8'd6, 8'd3, 8'd2, 1'b0);
        checks++; if (done_cyc != 32) begin errors++; $display("FAIL basic_done_cycle: got %0d want 32", done_cyc); end
        checks++; if (done_err !== 2'b00) begin errors++; $display("FAIL basic_err: got %b want 00", done_err); end
        checks++; if (start_cnt != 1 || start_cyc != 11) begin errors++; $display("FAIL basic_start: got %0d pulses at %0d want 1 at 11", start_cnt, start_cyc); end
        checks++; if (din6 !== 8'hFF) begin errors++; $display("FAIL basic_turnaround_din: got %h want ff", din6); end
        checks++; if (!busy_all || ready_any) begin errors++; $display("FAIL basic_busy_ready: busy_all %b ready_seen %b want 1 0", busy_all, ready_any); end
        checks++;
        if (bus_q.size() != exq.size()) begin errors++; $display("FAIL basic_bus_len: got %0d want %0d", bus_q.size(), exq.size()); end
        else foreach (exq[i]) begin
            checks++; if (bus_q[i] !== exq[i]) begin errors++; $display("FAIL basic_bus_beat%0d: got %h want %h", i, bus_q[i], exq[i]); end
        end
    endtask

    task automatic test_invalid();
        logic [31:0] cf [4];
        cf = '{{8'd3, 8'd6, 8'd3, 8'd2}, {8'd4, 8'd6, 8'd3, 8'd0}, rand_cfg(0), rand_cfg(2)};
        foreach (cf[i]) begin
            do_req(cf[i][31:24], cf[i][23:16], cf[i][15:8], cf[i][7:0], 1'b0, 30, 1'b0, 32'd0);
            checks++; if (done_cyc != 2 || done_err !== 2'b01) begin errors++; $display("FAIL invalid%0d_result: got cycle %0d err %b want 2 01", i, done_cyc, done_err); end
            checks++; if (bus_q.size() != 0 || start_cnt != 0) begin errors++; $display("FAIL invalid%0d_quiet: got %0d bus beats %0d starts want 0 0", i, bus_q.size(), start_cnt); end
            checks++; if (!busy_all || ready_any) begin errors++; $display("FAIL invalid%0d_busy: busy_all %b ready_seen %b want 1 0", i, busy_all, ready_any); end
            if (i > 0) begin
                checks++; if (acc_wait != 1) begin errors++; $display("FAIL invalid%0d_spacing: got wait %0d want 1", i, acc_wait); end
            end
        end
    endtask

    task automatic test_mismatch();
        evq_t exq;
        do_req(8'd4, 8'd6, 8'd3, 8'd2, 1'b1, 31, 1'b0, 32'd0);
        exq = exp_bus(8'd4, 8'd6, 8'd3, 8'd2, 1'b1);
        checks++; if (done_cyc != 11 || done_err !== 2'b10) begin errors++; $display("FAIL mismatch_result: got cycle %0d err %b want 11 10", done_cyc, done_err); end
        checks++; if (start_cnt != 0) begin errors++; $display("FAIL mismatch_start: got %0d pulses want 0", start_cnt); end
        checks++;
        if (bus_q.size() != exq.size()) begin errors++; $display("FAIL mismatch_bus_len: got %0d want %0d", bus_q.size(), exq.size()); end
        else foreach (exq[i]) begin
            checks++; if (bus_q[i] !== exq[i]) begin errors++; $display("FAIL mismatch_bus_beat%0d: got %h want %h", i, bus_q[i], exq[i]); end
        end
        @(negedge clk);
        checks++; if (err_code !== 2'b10 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mismatch_hold: got err %b ready %b want 10 1", err_code, cfg_ready); end
        corrupt = 1'b0;
    endtask

    task automatic test_timeout();
        int dc; logic [1:0] er;
        int ecs [2];
        ecs = '{0, 11 + TIMEOUT};
        foreach (ecs[i]) begin
            do_req(8'd4, 8'd6, 8'd3, 8'd2, 1'b0, ecs[i], 1'b0, 32'd0);
            exp_result(8'd4, 8'd6, 8'd3, 8'd2, 1'b0, ecs[i], dc, er);
            checks++; if (done_cyc != dc || done_err !== er) begin errors++; $display("FAIL timeout%0d_result: got cycle %0d err %b want %0d %b", i, done_cyc, done_err, dc, er); end
            checks++; if (start_cnt != 1) begin errors++; $display("FAIL timeout%0d_start: got %0d pulses want 1", i, start_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        evq_t exq;
        for (int w = 0; w < MAXC && cfg_ready !== 1'b1; w++) @(negedge clk);
        cfg_valid = 1'b1;
        {cfg_start, cfg_upper, cfg_lower, cfg_cycles} = {8'd4, 8'd6, 8'd3, 8'd2};
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ncs !== 1'b0 || {A1, A0} !== 2'd2 || din !== 8'h03) begin errors++; $display("FAIL rstmid_beat2: got ncs %b addr %0d din %h want 0 2 03", ncs, {A1, A0}, din); end
        rst = 1'b0;
        #1;
        checks++; if ({ncs, nwr, nrd} !== 3'b111 || din !== 8'hFF) begin errors++; $display("FAIL rstmid_bus: got strobes %b din %h want 111 ff", {ncs, nwr, nrd}, din); end
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || err_code !== 2'b00) begin errors++; $display("FAIL rstmid_status: got busy %b ready %b err %b want 0 1 00", busy, cfg_ready, err_code); end
        @(negedge clk);
        rst = 1'b1;
        do_req(8'd4, 8'd6, 8'd3, 8'd2, 1'b0, 20, 1'b0, 32'd0);
        exq = exp_bus(8'd4, 8'd6, 8'd3, 8'd2, 1'b0);
        checks++; if (done_cyc != 21 || done_err !== 2'b00) begin errors++; $display("FAIL rstmid_after: got cycle %0d err %b want 21 00", done_cyc, done_err); end
        checks++;
        if (bus_q.size() != exq.size()) begin errors++; $display("FAIL rstmid_bus_len: got %0d want %0d", bus_q.size(), exq.size()); end
        else foreach (exq[i]) begin
            checks++; if (bus_q[i] !== exq[i]) begin errors++; $display("FAIL rstmid_bus_beat%0d: got %h want %h", i, bus_q[i], exq[i]); end
        end
    endtask

    task automatic test_back_to_back();
        evq_t exq;
        logic [31:0] c2;
        c2 = rand_cfg(3);
        do_req(8'd4, 8'd6, 8'd3, 8'd2, 1'b0, 30, 1'b1, c2);
        checks++; if (done_cyc != 31 || done_err !== 2'b00) begin errors++; $display("FAIL b2b_first: got cycle %0d err %b want 31 00", done_cyc, done_err); end
        checks++; if (ready_any) begin errors++; $display("FAIL b2b_ready_while_busy: got ready 1 want 0"); end
        do_req(c2[31:24], c2[23:16], c2[15:8], c2[7:0], 1'b0, 25, 1'b0, 32'd0);
        exq = exp_bus(c2[31:24], c2[23:16], c2[15:8], c2[7:0], 1'b0);
        checks++; if (acc_wait != 1) begin errors++; $display("FAIL b2b_accept_gap: got %0d want 1", acc_wait); end
        checks++; if (done_cyc != 26 || done_err !== 2'b00) begin errors++; $display("FAIL b2b_second: got cycle %0d err %b want 26 00", done_cyc, done_err); end
        checks++;
        if (bus_q.size() != exq.size()) begin errors++; $display("FAIL b2b_bus_len: got %0d want %0d", bus_q.size(), exq.size()); end
        else foreach (exq[i]) begin
            checks++; if (bus_q[i] !== exq[i]) begin errors++; $display("FAIL b2b_bus_beat%0d: got %h want %h", i, bus_q[i], exq[i]); end
        end
    endtask

    task automatic test_random();
        evq_t exq;
        int dc; logic [1:0] er;
        logic [31:0] cf;
        bit corr;
        int ecc;
        for (int k = 0; k < 10; k++) begin
            cf   = rand_cfg(int'($urandom_range(0, 5)));
            corr = ($urandom_range(0, 3) == 0);
            ecc  = int'($urandom_range(12, 70));
            do_req(cf[31:24], cf[23:16], cf[15:8], cf[7:0], corr, ecc, 1'b0, 32'd0);
            exp_result(cf[31:24], cf[23:16], cf[15:8], cf[7:0], corr, ecc, dc, er);
            exq = exp_bus(cf[31:24], cf[23:16], cf[15:8], cf[7:0], corr);
            checks++; if (done_cyc != dc || done_err !== er) begin errors++; $display("FAIL rand%0d_result: cfg %h got cycle %0d err %b want %0d %b", k, cf, done_cyc, done_err, dc, er); end
            checks++; if (start_cnt != ((er == 2'b00 || er == 2'b11) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_start: got %0d pulses for err %b", k, start_cnt, er); end
            checks++;
            if (bus_q.size() != exq.size()) begin errors++; $display("FAIL rand%0d_bus_len: got %0d want %0d", k, bus_q.size(), exq.size()); end
            else foreach (exq[i]) begin
                checks++; if (bus_q[i] !== exq[i]) begin errors++; $display("FAIL rand%0d_bus_beat%0d: got %h want %h", k, i, bus_q[i], exq[i]); end
            end
        end
        corrupt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_mismatch();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udc_bus_loader.md
# udc_bus_loader

Bus-master sequencer upstream of the up/down counter. It accepts one counter configuration (start value, upper limit, lower limit, cycle count) over a valid/ready handshake and validates it. It then writes the four counter registers over the counter's 8-bit register bus (A1/A0, ncs, nwr, nrd), reads them back and compares, pulses `start`, and waits for the counter's `ec`. It reports completion and an error code to the controlling logic.

## Interface
- `TIMEOUT`, default 4000: maximum cycles spent in RUN waiting for `ec` before error 11.
- `TO_W`, default 12: width of the timeout counter. Requires TIMEOUT < 2^TO_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: loader idle and able to accept.
- `cfg_start` in 8: counter start value (register 00).
- `cfg_upper` in 8: upper limit (register 01).
- `cfg_lower` in 8: lower limit (register 10).
- `cfg_cycles` in 8: number of up/down cycles (register 11).
- `A0`, `A1` out 1: register address, {A1,A0}.
- `ncs`, `nwr`, `nrd` out 1: active-low chip select, write strobe and read strobe.
- `din` inout 8: register data bus. Driven only during write beats, Z otherwise.
- `start` out 1: one-cycle counter start pulse.
- `ec` in 1: end-of-count from the counter.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of every accepted request, whether it succeeded or failed.
- `err_code` out 2: result of the request. 00 ok, 01 invalid config, 10 readback mismatch, 11 timeout. Valid from the `done` pulse and held until the next accept.

## Operation
- States: IDLE, CHECK, WR, TA, RD, START, RUN, FIN.
- IDLE: `cfg_ready`=1. On `cfg_valid`&&`cfg_ready`, all four config bytes are latched, `err_code` is cleared, and the FSM goes to CHECK.
- CHECK (1 cycle): the config is legal if `cfg_lower` < `cfg_start` < `cfg_upper` (unsigned) and `cfg_cycles` != 0.
  - Legal: go to WR with beat index 0.
  - Illegal: set `err_code`=01 and go to FIN. No bus activity occurs.
- WR (4 cycles, beat index 0..3): `ncs`=0, `nwr`=0, `nrd`=1, {A1,A0}=index, `din` driven with the latched byte for that address. After beat 3, go to TA.
- TA (1 cycle): `ncs`=`nwr`=`nrd`=1 and `din` released. This is the bus turnaround. Go to RD.
- RD (4 cycles, index 0..3): `ncs`=0, `nrd`=0, `nwr`=1, `din` Z.
  - `din` is sampled on the clock edge that ends each beat and compared with the latched byte.
  - Any mismatch sets a sticky mismatch flag.
  - After beat 3: if the flag is set, set `err_code`=10 and go to FIN; otherwise go to START.
- START (1 cycle): bus idle, `start`=1. Clear the timeout counter and go to RUN.
- RUN: the timeout counter increments every cycle.
  - `ec`=1: go to FIN, `err_code`=00.
  - Counter reaches TIMEOUT with no `ec`: set `err_code`=11 and go to FIN.
  - `ec` in the same cycle the counter reaches TIMEOUT: success wins.
- FIN (1 cycle): `done`=1. Go to IDLE.
- Inputs ignored:
  - `ec` outside RUN.
  - `cfg_valid` while `busy`. The request is neither latched nor lost; it stays pending until `cfg_ready`.
  - Config inputs outside the accept cycle.

## Timing
- All outputs are registered. `din` is driven through a registered output enable.
- Reset values:
  - `ncs`=`nwr`=`nrd`=1, {A1,A0}=00, `din`=Z.
  - `start`=0, `busy`=0, `done`=0, `err_code`=00.
  - `cfg_ready`=1, FSM in IDLE.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge, and releases the bus. Operation resumes from IDLE.
- Latency, with accept on edge E0:
  - CHECK in cycle 1.
  - Write beats in cycles 2–5.
  - TA in cycle 6.
  - Read beats in cycles 7–10.
  - `start` high in cycle 11.
  - RUN from cycle 12.
- `done` is asserted one cycle after the RUN exit condition.
- Invalid config: `done` in cycle 2, `busy` high in cycles 1–2.
- Back-to-back requests: `cfg_ready` returns to 1 the cycle after `done`. The minimum spacing between accepts is therefore 3 cycles for an invalid config.

## Test plan
- Config 4/6/3/2 with a counter model that responds correctly:
  - Write beats carry `din`=04,06,03,02 on addresses 00..11 in cycles 2–5.
  - Reads return the same bytes.
  - `start` is a single pulse in cycle 11.
  - `ec` asserted 20 cycles later gives `done` with `err_code`=00.
- Config start=3, lower=3 (and, separately, cycles=0): no `ncs` activity, `done` in cycle 2, `err_code`=01, `start` never asserted.
- Counter model returns 07 at address 01 during readback: `err_code`=10, `done` in cycle 11, `start` never asserted.
- `ec` held low with TIMEOUT=50: `done` follows 50 cycles in RUN, `err_code`=11. Repeat with `ec` rising exactly at the timeout cycle: `err_code`=00.
- `rst` asserted low during write beat 2: bus idles (`ncs`=1, `din`=Z) immediately. After release, a new 4/6/3/2 request completes normally.
- `cfg_valid` held high with a new config during RUN: `cfg_ready`=0 and the request is not latched. It is accepted in the cycle after `done`, and its bytes appear on the following write beats.
